// File: rtl/pulse_stretch_queue_pkg.sv
// Shared types, default timings and width helpers for the pulse stretch queue.
// No logic; compile-time only.
// Imported by the top and the queue counter.
package pulse_stretch_queue_pkg;

   // Stretcher FSM states; level is high only in ST_HIGH
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   // Default timings for the LED indicator path (slow_clock cycles)
   localparam int unsigned LED_HIGH_CYCLES = 200;
   localparam int unsigned LED_GAP_CYCLES  = 100;
   localparam int unsigned LED_PEND_MAX    = 7;

   // Bits needed to hold values 0 .. n-1, never less than one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      if (n <= 2) begin
         return 1;
      end
      return $clog2(n);
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pulse_stretch_queue_counter.sv
// Saturating up/down counter of queued pulses with a sticky overflow flag.
// Latency: count and overflow update one cycle after inc/dec/clr.
// No backpressure: an increment at MAX is dropped and flagged instead.
module pulse_queue_counter
   import pulse_stretch_queue_pkg::*;
#(
   parameter int unsigned MAX = LED_PEND_MAX,
   parameter int unsigned W   = cnt_width(LED_PEND_MAX + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         overflow
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] count_q, count_d;
   logic         ovf_q, ovf_d;

   // Next count: inc+dec together is one-in-one-out, so it can never saturate
   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      if (clr) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (inc && dec) begin
         if (count_q == '0) begin
            count_d = count_q + 1'b1;
         end
      end else if (inc) begin
         if (count_q == MAX_V) begin
            ovf_d = 1'b1;
         end else begin
            count_d = count_q + 1'b1;
         end
      end else if (dec) begin
         if (count_q != '0) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   // Count and sticky flag registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count    = count_q;
   assign overflow = ovf_q;

endmodule

// File: rtl/pulse_stretch_queue.sv
// Turns single-cycle pulses into fixed HIGH windows separated by fixed LOW gaps, queueing extras.
// Latency: level rises one cycle after a pulse accepted in IDLE; queued pulses replay after each gap.
// No backpressure: pulses beyond PEND_MAX are dropped and flagged on the sticky overflow output.
module pulse_stretch_queue
   import pulse_stretch_queue_pkg::*;
#(
   parameter int unsigned HIGH_CYCLES = LED_HIGH_CYCLES,
   parameter int unsigned GAP_CYCLES  = LED_GAP_CYCLES,
   parameter int unsigned PEND_MAX    = LED_PEND_MAX,
   localparam int unsigned PW         = cnt_width(PEND_MAX + 1)
) (
   input  logic          slow_clock,
   input  logic          rst_n,
   input  logic          pulse,
   input  logic          clear,
   output logic          level,
   output logic          busy,
   output logic [PW-1:0] pending,
   output logic          overflow
);

   localparam int unsigned CW = cnt_width(max_u(HIGH_CYCLES, GAP_CYCLES));
   localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, busy_q;
   logic          q_inc, q_dec;
   logic [PW-1:0] pend;

   // Next state, timer and queue requests; a pulse at gap end is replayed directly or swaps with the queue head
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_inc   = 1'b0;
      q_dec   = 1'b0;
      if (clear) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pulse) begin
                  state_d = ST_HIGH;
                  cnt_d   = HIGH_LOAD;
               end
            end
            ST_HIGH: begin
               q_inc = pulse;
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - 1'b1;
               end else begin
                  state_d = ST_GAP;
                  cnt_d   = GAP_LOAD;
               end
            end
            ST_GAP: begin
               if (cnt_q != '0) begin
                  q_inc = pulse;
                  cnt_d = cnt_q - 1'b1;
               end else if (pend != '0) begin
                  state_d = ST_HIGH;
                  cnt_d   = HIGH_LOAD;
                  q_dec   = 1'b1;
                  q_inc   = pulse;
               end else if (pulse) begin
                  state_d = ST_HIGH;
                  cnt_d   = HIGH_LOAD;
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // FSM register with outputs decoded from the next state so they are registered
   always_ff @(posedge slow_clock) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         level_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= (state_d == ST_HIGH);
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   pulse_queue_counter #(
      .MAX (PEND_MAX),
      .W   (PW)
   ) u_queue (
      .clk      (slow_clock),
      .rst_n    (rst_n),
      .clr      (clear),
      .inc      (q_inc),
      .dec      (q_dec),
      .count    (pend),
      .overflow (overflow)
   );

   assign level   = level_q;
   assign busy    = busy_q;
   assign pending = pend;

endmodule

// File: tb/tb_pulse_stretch_queue.sv
// Directed bench for pulse_stretch_queue with HIGH=3, GAP=2, PEND_MAX=2.
// Each scenario starts from reset and checks every output on every cycle 0..31.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_pulse_stretch_queue;

   localparam int PW = 2;

   logic          slow_clock = 1'b0;
   logic          rst_n;
   logic          pulse;
   logic          clear;
   logic          level;
   logic          busy;
   logic [PW-1:0] pending;
   logic          overflow;

   int tests = 0;
   int fails = 0;

   always #5 slow_clock = ~slow_clock;

   pulse_stretch_queue #(
      .HIGH_CYCLES (3),
      .GAP_CYCLES  (2),
      .PEND_MAX    (2)
   ) dut (
      .slow_clock (slow_clock),
      .rst_n      (rst_n),
      .pulse      (pulse),
      .clear      (clear),
      .level      (level),
      .busy       (busy),
      .pending    (pending),
      .overflow   (overflow)
   );

   function automatic logic [31:0] b(input int i);
      logic [31:0] m;
      m = 32'd1;
      return m << i;
   endfunction

   function automatic logic [31:0] rng(input int lo, input int hi);
      logic [31:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic chk1(input string tag, input int c, input logic got, input logic want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s c%0d got %b expected %b", tag, c, got, want);
      end
   endtask

   task automatic chkp(input string tag, input int c, input logic [PW-1:0] got, input logic [PW-1:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s c%0d got %0d expected %0d", tag, c, got, want);
      end
   endtask

   // pm/cm/rm: pulse, clear, reset-low stimulus per cycle; lm/bm/om: expected level/busy/overflow;
   // p1m/p2m: cycles where pending is expected to be 1 or 2
   task automatic run_scn(input string name,
                          input logic [31:0] pm, input logic [31:0] cm, input logic [31:0] rm,
                          input logic [31:0] lm, input logic [31:0] bm,
                          input logic [31:0] p1m, input logic [31:0] p2m, input logic [31:0] om);
      logic [PW-1:0] want_p;
      rst_n = 1'b0;
      pulse = 1'b0;
      clear = 1'b0;
      repeat (2) begin
         @(posedge slow_clock);
         @(negedge slow_clock);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 32; c++) begin
         want_p = p2m[c] ? 2'd2 : (p1m[c] ? 2'd1 : 2'd0);
         chk1({name, ".level"},    c, level,    lm[c]);
         chk1({name, ".busy"},     c, busy,     bm[c]);
         chkp({name, ".pending"},  c, pending,  want_p);
         chk1({name, ".overflow"}, c, overflow, om[c]);
         pulse = pm[c];
         clear = cm[c];
         rst_n = ~rm[c];
         @(posedge slow_clock);
         @(negedge slow_clock);
      end
      pulse = 1'b0;
      clear = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      // single pulse from idle
      run_scn("single", b(10), '0, '0,
              rng(11, 13), rng(11, 15), '0, '0, '0);
      // two pulses, second queued during the first window
      run_scn("queued", b(10) | b(12), '0, '0,
              rng(11, 13) | rng(16, 18), rng(11, 20), rng(13, 15), '0, '0);
      // four rapid pulses: queue saturates at 2, fourth dropped
      run_scn("saturate", rng(10, 13), '0, '0,
              rng(11, 13) | rng(16, 18) | rng(21, 23), rng(11, 25),
              b(12) | rng(16, 20), rng(13, 15), rng(14, 31));
      // pulse on the last gap cycle with empty queue is consumed directly
      run_scn("gapend", b(10) | b(15), '0, '0,
              rng(11, 13) | rng(16, 18), rng(11, 20), '0, '0, '0);
      // full queue plus overflow, then clear together with a pulse
      run_scn("clear", rng(8, 12), b(12), '0,
              rng(9, 11), rng(9, 12), b(10), rng(11, 12), b(12));
      // reset mid-window with one queued pulse: no replay
      run_scn("reset", b(10) | b(11), '0, b(12),
              rng(11, 12), rng(11, 12), b(12), '0, '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
